// File: rtl/fir_l3_coef_ctrl.sv
// Coefficient shadow/active bank controller and valid tracker for the 3-parallel FIR.
// Optional register readback port enabled by defining COEF_READBACK_EN.
module fir_l3_coef_ctrl #(
  parameter int TAPS       = 100,
  parameter int COEF_WIDTH = 16,
  parameter int ADDR_WIDTH = 7,
  parameter int PIPE_LAT   = 102
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_wr_en,
  input  logic [ADDR_WIDTH-1:0]        cfg_wr_addr,
  input  logic signed [COEF_WIDTH-1:0] cfg_wr_data,
  input  logic                         cfg_commit,
  output logic                         cfg_busy,
  output logic                         cfg_err,
  output logic                         cfg_done,
  input  logic                         in_valid,
  output logic [TAPS*COEF_WIDTH-1:0]   coef_out,
`ifdef COEF_READBACK_EN
  input  logic                         rd_en,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic                         rd_sel,
  output logic signed [COEF_WIDTH-1:0] rd_data,
  output logic                         rd_valid,
`endif
  output logic                         out_valid
);

  localparam int CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PIPE_LAT - 1);
  localparam logic [ADDR_WIDTH:0] TAPS_L = (ADDR_WIDTH + 1)'(TAPS);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t                         state_r;
  logic [CNT_W-1:0]               cnt_r;
  logic signed [COEF_WIDTH-1:0]   shadow_r [TAPS];
  logic signed [COEF_WIDTH-1:0]   active_r [TAPS];
  logic [TAPS-1:0]                mask_r;
  logic [TAPS-1:0]                mask_nx_s;
  logic [TAPS-1:0]                wr_bit_s;
  logic [PIPE_LAT-1:0]            vpipe_r;
  logic                           wr_ok_s;
  logic                           wr_bad_s;
  logic                           commit_ok_s;
  logic                           commit_bad_s;
  logic                           rd_bad_s;
  logic                           err_s;

  // Classify this cycle's write and commit requests; commit sees the pre-write mask.
  always_comb begin
    wr_ok_s      = 1'b0;
    wr_bad_s     = 1'b0;
    commit_ok_s  = 1'b0;
    commit_bad_s = 1'b0;
    if (cfg_wr_en) begin
      if ({1'b0, cfg_wr_addr} < TAPS_L) begin
        wr_ok_s = 1'b1;
      end else begin
        wr_bad_s = 1'b1;
      end
    end else begin
      wr_ok_s  = 1'b0;
      wr_bad_s = 1'b0;
    end
    if (cfg_commit) begin
      if ((state_r == RUN) && (&mask_r)) begin
        commit_ok_s = 1'b1;
      end else begin
        commit_bad_s = 1'b1;
      end
    end else begin
      commit_ok_s  = 1'b0;
      commit_bad_s = 1'b0;
    end
  end

  // An accepted commit empties the mask, then a same-cycle write re-marks its own tap.
  assign wr_bit_s  = wr_ok_s ? (TAPS'(1'b1) << cfg_wr_addr) : '0;
  assign mask_nx_s = (commit_ok_s ? '0 : mask_r) | wr_bit_s;
  assign err_s     = wr_bad_s | commit_bad_s | rd_bad_s;

  // Bank storage, write mask and RUN/FLUSH sequencing with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= RUN;
      cnt_r    <= '0;
      mask_r   <= '0;
      cfg_busy <= 1'b0;
      cfg_err  <= 1'b0;
      cfg_done <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        shadow_r[k] <= '0;
        active_r[k] <= '0;
      end
    end else begin
      mask_r   <= mask_nx_s;
      cfg_err  <= err_s;
      cfg_done <= 1'b0;
      if (commit_ok_s) begin
        active_r <= shadow_r;
      end
      if (wr_ok_s) begin
        shadow_r[cfg_wr_addr] <= cfg_wr_data;
      end
      case (state_r)
        RUN: begin
          if (commit_ok_s) begin
            state_r  <= FLUSH;
            cnt_r    <= CNT_LOAD;
            cfg_busy <= 1'b1;
          end
        end
        FLUSH: begin
          if (cnt_r == '0) begin
            state_r  <= RUN;
            cfg_busy <= 1'b0;
            cfg_done <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r  <= RUN;
          cfg_busy <= 1'b0;
        end
      endcase
    end
  end

  // Block-valid delay line; a swap wipes every sample in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe_r <= '0;
    end else if (commit_ok_s) begin
      vpipe_r <= '0;
    end else begin
      vpipe_r <= {vpipe_r[PIPE_LAT-2:0], in_valid};
    end
  end

  assign out_valid = vpipe_r[PIPE_LAT-1];

  for (genvar k = 0; k < TAPS; k++) begin : g_coef
    assign coef_out[k*COEF_WIDTH +: COEF_WIDTH] = active_r[k];
  end

`ifdef COEF_READBACK_EN
  logic rd_ok_s;

  assign rd_ok_s  = rd_en && ({1'b0, rd_addr} < TAPS_L);
  assign rd_bad_s = rd_en && !rd_ok_s;

  // Registered readback; reads the pre-edge bank so a same-cycle write returns old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_ok_s) begin
        rd_data <= rd_sel ? shadow_r[rd_addr] : active_r[rd_addr];
      end else begin
        rd_data <= '0;
      end
    end
  end
`else
  assign rd_bad_s = 1'b0;
`endif

endmodule

// File: tb/tb_fir_l3_coef_ctrl.sv
// Self-checking bench for fir_l3_coef_ctrl: directed plan plus randomized loads,
// checked every cycle against an event-time reference model.
module tb_fir_l3_coef_ctrl;

  localparam int TAPS = 100;
  localparam int CW   = 16;
  localparam int AW   = 7;
  localparam int L    = 102;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_wr_en = 1'b0;
  logic [AW-1:0]     cfg_wr_addr = '0;
  logic [CW-1:0]     cfg_wr_data = '0;
  logic              cfg_commit = 1'b0;
  logic              in_valid = 1'b0;
  logic              cfg_busy;
  logic              cfg_err;
  logic              cfg_done;
  logic [TAPS*CW-1:0] coef_out;
  logic              out_valid;

  always #5 clk = ~clk;

  fir_l3_coef_ctrl #(
    .TAPS(TAPS), .COEF_WIDTH(CW), .ADDR_WIDTH(AW), .PIPE_LAT(L)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .cfg_err(cfg_err), .cfg_done(cfg_done),
    .in_valid(in_valid), .coef_out(coef_out), .out_valid(out_valid)
  );

  int vectors = 0;
  int fails   = 0;

  // Reference model: banks as arrays, timing as "cycle of last swap / last pipe kill".
  logic [CW-1:0] m_sh  [TAPS];
  logic [CW-1:0] m_act [TAPS];
  bit            m_mask[TAPS];
  bit            iv_hist[65536];
  int            cyc        = 0;
  int            commit_cyc = -100000;
  int            kill_cyc   = 0;
  bit            exp_err    = 1'b0;

  function automatic bit mask_full();
    bit f = 1'b1;
    for (int i = 0; i < TAPS; i++) f = f & m_mask[i];
    return f;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_coef();
    logic [TAPS*CW-1:0] e;
    int bad;
    for (int i = 0; i < TAPS; i++) e[i*CW +: CW] = m_act[i];
    vectors++;
    assert (coef_out === e) else begin
      fails++;
      bad = 0;
      for (int i = TAPS - 1; i >= 0; i--) if (coef_out[i*CW +: CW] !== e[i*CW +: CW]) bad = i;
      $error("FAIL coef_out cyc=%0d tap=%0d observed=%0h expected=%0h",
             cyc, bad, coef_out[bad*CW +: CW], e[bad*CW +: CW]);
    end
  endtask

  // Apply current inputs for one cycle, advance the model, then compare all outputs.
  task automatic tick();
    bit busy_now, acc, wr_ok, ov;
    int d;
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        m_sh[i]   = '0;
        m_act[i]  = '0;
        m_mask[i] = 1'b0;
      end
      commit_cyc = -100000;
      kill_cyc   = cyc;
      exp_err    = 1'b0;
    end else begin
      d        = cyc - commit_cyc;
      busy_now = (d >= 1) && (d <= L);
      acc      = cfg_commit && !busy_now && mask_full();
      wr_ok    = cfg_wr_en && (int'(cfg_wr_addr) < TAPS);
      exp_err  = (cfg_commit && !acc) || (cfg_wr_en && !wr_ok);
      if (acc) begin
        for (int i = 0; i < TAPS; i++) begin
          m_act[i]  = m_sh[i];
          m_mask[i] = 1'b0;
        end
        commit_cyc = cyc;
        kill_cyc   = cyc;
      end
      if (wr_ok) begin
        m_sh[int'(cfg_wr_addr)]   = cfg_wr_data;
        m_mask[int'(cfg_wr_addr)] = 1'b1;
      end
    end
    iv_hist[cyc] = in_valid;
    @(posedge clk);
    cyc++;
    #1;
    d  = cyc - commit_cyc;
    ov = (cyc >= L) && iv_hist[cyc - L] && (kill_cyc < cyc - L);
    check("cfg_busy", {31'd0, cfg_busy}, {31'd0, (d >= 1) && (d <= L)});
    check("cfg_done", {31'd0, cfg_done}, {31'd0, d == L + 1});
    check("cfg_err", {31'd0, cfg_err}, {31'd0, exp_err});
    check("out_valid", {31'd0, out_valid}, {31'd0, ov});
    check_coef();
    cfg_wr_en  = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input int a, input logic [CW-1:0] d);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = AW'(a);
    cfg_wr_data = d;
    tick();
  endtask

  task automatic commit_req();
    cfg_commit = 1'b1;
    tick();
  endtask

  task automatic load_all(input int skip);
    for (int k = 0; k < TAPS; k++) begin
      if (k != skip) wr(k, CW'($urandom));
    end
  endtask

  initial begin
    int off;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    tick();

    // Full ramp load and commit
    for (int k = 0; k < TAPS; k++) wr(k, CW'(k + 1));
    commit_req();
    check("tap0_after_commit", {16'd0, coef_out[0 +: CW]}, 32'd1);
    check("tap99_after_commit", {16'd0, coef_out[99*CW +: CW]}, 32'd100);
    idle(L + 3);

    // Incomplete mask rejected, completing it allows the swap
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < TAPS - 1; k++) wr(k, CW'($urandom));
    commit_req();
    idle(2);
    wr(99, 16'h7FFF);
    commit_req();
    check("tap99_7fff", {16'd0, coef_out[99*CW +: CW]}, 32'h0000_7FFF);
    idle(10);
    commit_req();
    idle(L);

    // Out-of-range writes, then commit with empty mask
    wr(100, 16'h1234);
    idle(1);
    wr(127, 16'h4321);
    idle(1);
    commit_req();

    // Continuous in_valid across a swap
    in_valid = 1'b1;
    load_all(-1);
    idle(L + 5);
    commit_req();
    idle(L + 10);
    in_valid = 1'b0;

    // Same-cycle write and accepted commit
    load_all(-1);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = AW'(5);
    cfg_wr_data = 16'h8000;
    cfg_commit  = 1'b1;
    tick();
    idle(L + 2);
    commit_req();
    load_all(5);
    commit_req();
    check("tap5_8000", {16'd0, coef_out[5*CW +: CW]}, 32'h0000_8000);
    idle(L + 2);

    // Reset during FLUSH, then commit on an empty mask
    load_all(-1);
    in_valid = 1'b1;
    commit_req();
    idle(39);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("coef_zero_after_rst", {31'd0, coef_out == '0}, 32'd1);
    commit_req();
    idle(2);

    // Randomized loads with interleaved junk, stray commits and random in_valid
    for (int r = 0; r < 8; r++) begin
      off = int'($urandom_range(0, TAPS - 1));
      for (int k = 0; k < TAPS; k++) begin
        in_valid   = 1'(($urandom_range(0, 1)));
        cfg_commit = ($urandom_range(0, 30) == 0);
        if ($urandom_range(0, 15) == 0) wr(int'($urandom_range(100, 127)), CW'($urandom));
        else wr((k + off) % TAPS, CW'($urandom));
      end
      in_valid = 1'(($urandom_range(0, 1)));
      commit_req();
      for (int j = int'($urandom_range(0, 120)); j > 0; j--) begin
        in_valid = 1'(($urandom_range(0, 1)));
        tick();
      end
    end
    in_valid = 1'b0;
    idle(L + 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
